// File: rtl/ipsmacge_txseq.sv
// GE MAC transmit frame sequencer: walks IPG, preamble, payload, pad, FCS and
// pause-frame fields one byte per txen slot, with pause-quanta deferral of data frames.
module ipsmacge_txseq #(
  parameter int CNT_W     = 14,
  parameter int IPG_LEN   = 12,
  parameter int PRM_LEN   = 8,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1514,
  parameter int FCS_LEN   = 4,
  parameter int PAU_LEN   = 60,
  parameter int QNT_BYTES = 64
) (
  input  logic             txrst_,
  input  logic             txclk,
  input  logic             up_en,
  input  logic             istable,
  input  logic             txen,
  input  logic             fcs_en,
  input  logic             sreq,
  input  logic             sdat_eop,
  input  logic             sdat_err,
  input  logic             pau_req,
  input  logic             pau_ld,
  input  logic [15:0]      pau_qnt,
  output logic [3:0]       stt_mach,
  output logic [CNT_W-1:0] fld_cnt,
  output logic [CNT_W-1:0] frm_len,
  output logic             sdat_rd,
  output logic             frm_done,
  output logic             frm_err,
  output logic             pau_busy
);

  localparam int QW = (QNT_BYTES > 1) ? $clog2(QNT_BYTES) : 1;
  localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_LEN - 1);
  localparam logic [CNT_W-1:0] PRM_LAST = CNT_W'(PRM_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_LEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_LEN - 1);
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_LEN - 1);
  localparam logic [CNT_W-1:0] PAU_LAST = CNT_W'(PAU_LEN - 1);
  localparam logic [QW-1:0]    QNT_LAST = QW'(QNT_BYTES - 1);

  typedef enum logic [3:0] {
    IGAP = 4'd0, IRDY = 4'd1, IPRM = 4'd2, IPAY = 4'd3, IFCS = 4'd4,
    IFCE = 4'd5, IPAU = 4'd6, IPAD = 4'd7, IDIS = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] fld_q, fld_d, len_q, len_d;
  logic             err_q, err_d, pflag_q, pflag_d;
  logic [15:0]      pcnt_q, pcnt_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             run, abort, qnt_wrap, fcs_end, nofcs_end;

  // Handshake: txen is the byte slot strobe; a payload byte is consumed from
  // the buffer in exactly the cycles where sdat_rd and txen are both high.
  assign run       = up_en & istable;
  assign pau_busy  = (pcnt_q != 16'd0);
  assign abort     = (state_q == IPAY) && (len_q == MAX_LAST) && !sdat_eop;
  assign sdat_rd   = run && txen && (state_q == IPAY) && !abort;
  assign fcs_end   = ((state_q == IFCS) || (state_q == IFCE)) && (fld_q == FCS_LAST);
  assign nofcs_end = !fcs_en &&
                     (((state_q == IPAY) && sdat_eop && (len_q >= MIN_LAST)) ||
                      ((state_q == IPAD) && (len_q == MIN_LAST)));
  assign frm_done  = run && txen && (fcs_end || nofcs_end);
  assign frm_err   = frm_done && (state_q == IFCE);
  assign stt_mach  = state_q;
  assign fld_cnt   = fld_q;
  assign frm_len   = len_q;
  assign qnt_wrap  = txen && (qcnt_q == QNT_LAST);

  // Pause quanta: load beats a same-cycle decrement; config disable beats both.
  always_comb begin
    qcnt_d = qcnt_q;
    pcnt_d = pcnt_q;
    if (txen) qcnt_d = qnt_wrap ? '0 : qcnt_q + 1'b1;
    if (qnt_wrap && pau_busy) pcnt_d = pcnt_q - 16'd1;
    if (pau_ld) begin
      pcnt_d = pau_qnt;
      qcnt_d = '0;
    end
    if (!up_en) pcnt_d = '0;
  end

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    len_d   = len_q;
    err_d   = err_q;
    pflag_d = pflag_q;
    if (!run) begin
      state_d = IGAP;
      fld_d   = '0;
      len_d   = '0;
      err_d   = 1'b0;
      pflag_d = 1'b0;
    end else if (txen) begin
      case (state_q)
        IGAP: if (fld_q == IPG_LAST) state_d = IRDY;
        IRDY: begin
          if (pau_req) begin
            state_d = IPRM;
            pflag_d = 1'b1;
          end else if (pau_busy) state_d = IDIS;
          else if (sreq)         state_d = IPRM;
        end
        IDIS: if (pau_req || !pau_busy) state_d = IRDY;
        IPRM: if (fld_q == PRM_LAST) state_d = pflag_q ? IPAU : IPAY;
        IPAY: begin
          len_d = len_q + CNT_W'(1);
          if (sdat_err) err_d = 1'b1;
          if (abort) begin
            state_d = IFCE;
            err_d   = 1'b1;
          end else if (sdat_eop) begin
            if (len_q < MIN_LAST) state_d = IPAD;
            else if (fcs_en)      state_d = (sdat_err || err_q) ? IFCE : IFCS;
            else                  state_d = IGAP;
          end
        end
        IPAD: begin
          len_d = len_q + CNT_W'(1);
          if (len_q == MIN_LAST) begin
            if (fcs_en) state_d = err_q ? IFCE : IFCS;
            else        state_d = IGAP;
          end
        end
        IPAU: if (fld_q == PAU_LAST) begin
          state_d = IFCS;
          pflag_d = 1'b0;
        end
        IFCS, IFCE: if (fld_q == FCS_LAST) state_d = IGAP;
        default: state_d = IGAP;
      endcase
      fld_d = (state_d != state_q) ? '0 : fld_q + CNT_W'(1);
      // Every path back to the gap closes the frame.
      if ((state_d == IGAP) && (state_q != IGAP)) begin
        len_d = '0;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge txclk or negedge txrst_) begin
    if (!txrst_) begin
      state_q <= IGAP;
      fld_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      pflag_q <= 1'b0;
      pcnt_q  <= '0;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      len_q   <= len_d;
      err_q   <= err_d;
      pflag_q <= pflag_d;
      pcnt_q  <= pcnt_d;
      qcnt_q  <= qcnt_d;
    end
  end

endmodule

// File: doc/ipsmacge_txseq.md
Name: ipsmacge_txseq

Overview:
- Self-contained, parametrised GE MAC transmit frame sequencer.
- Replaces the externally-fed next-state block with an internal state register and field byte counters: IPG, preamble, minimum-length padding, FCS, MAC-control pause frame body and pause-quanta deferral.
- Sits between the TX payload buffer and the TX byte mux/CRC engine. It advances one byte per txen cycle.

Parameters:
- CNT_W, 14, width of byte counters; must satisfy 2^CNT_W > MAX_LEN.
- IPG_LEN, 12, inter-packet gap bytes.
- PRM_LEN, 8, preamble+SFD bytes.
- MIN_LEN, 60, minimum payload+pad bytes (excluding FCS).
- MAX_LEN, 1514, maximum payload bytes before forced abort.
- FCS_LEN, 4, FCS bytes.
- PAU_LEN, 60, pause frame body bytes (DA..pad).
- QNT_BYTES, 64, byte-times per pause quantum.

Ports:
- txrst_ in 1: asynchronous active-low reset.
- txclk in 1: TX clock, the single clock of the block.
- up_en in 1: config enable; low forces idle.
- istable in 1: link stable; low forces idle.
- txen in 1: byte slot valid; all sequencing advances only when high.
- fcs_en in 1: config; append FCS to data frames.
- sreq in 1: a payload frame is available in the buffer.
- sdat_eop in 1: current payload byte is the last.
- sdat_err in 1: current frame is corrupt; force a bad FCS.
- pau_req in 1: request to transmit a pause frame.
- pau_ld in 1: load the received pause quanta.
- pau_qnt in 16: received pause quanta value.
- stt_mach out 4: current state.
- fld_cnt out CNT_W: byte index within the current field.
- frm_len out CNT_W: payload+pad bytes sent in the current frame.
- sdat_rd out 1: pop one payload byte (combinational: state==IPAY & txen & ~abort).
- frm_done out 1: one-cycle pulse on the last FCS byte, or on the last pad/payload byte when FCS is not sent.
- frm_err out 1: one-cycle pulse with frm_done when the frame ended in IFCE or was aborted.
- pau_busy out 1: pause counter nonzero.

Behaviour:
- Reset values: all outputs 0, stt_mach=IGAP(0), all counters 0, pause flag 0, error flag 0.
- up_en=0 or istable=0 (synchronous, checked before txen): state->IGAP, fld_cnt/frm_len/error/pause flags cleared.
  - up_en=0 additionally clears the pause counter.
  - istable=0 preserves the pause counter.
- Encoding: IGAP 0, IRDY 1, IPRM 2, IPAY 3, IFCS 4, IFCE 5, IPAU 6, IPAD 7, IDIS 8. Unused codes -> IGAP.
- fld_cnt resets to 0 on every state change and increments on each txen byte within a state.
- Transitions are evaluated only when txen=1:
  - IGAP: at fld_cnt==IPG_LEN-1 -> IRDY.
  - IRDY priority:
    - pau_req -> IPRM, set pause flag.
    - else pau_busy -> IDIS.
    - else sreq -> IPRM.
    - else stay.
  - IDIS: pau_req or ~pau_busy -> IRDY.
  - IPRM: at fld_cnt==PRM_LEN-1 -> IPAU if pause flag, else IPAY.
  - IPAY: frm_len increments per byte. Priority:
    - frm_len==MAX_LEN-1 without sdat_eop -> abort: IFCE, error flag set. sdat_rd stays low for the rest of the frame, and the buffer discards the remainder.
    - sdat_eop with frm_len+1<MIN_LEN -> IPAD.
    - sdat_eop otherwise -> IFCE if (sdat_err|error flag) else IFCS when fcs_en; IGAP when ~fcs_en.
    - sdat_err without eop sets the error flag.
  - IPAD: frm_len increments. At frm_len==MIN_LEN-1 -> IFCE/IFCS per the error flag when fcs_en, else IGAP.
  - IPAU: at fld_cnt==PAU_LEN-1 -> IFCS, regardless of fcs_en; clear the pause flag.
  - IFCS and IFCE: at fld_cnt==FCS_LEN-1 -> IGAP, frm_len cleared.
- IFCE means the downstream inverts the CRC. The error flag holds for the whole FCS field.
- Pause counter (16 bit) and quantum counter:
  - Quantum counter counts txen cycles modulo QNT_BYTES. At wrap, a nonzero pause counter decrements.
  - pau_ld loads pau_qnt and clears the quantum counter; load wins over a same-cycle decrement.
  - The counter never goes below 0.
  - Pause deferral only blocks the IRDY->IPRM start of data frames. A frame already in progress is never interrupted.
- Back-to-back frames always pass through IGAP with the full IPG.

Test Plan:
- Reset, then up_en=1, istable=1, txen=1 continuously, sreq=1, a 64-byte payload with eop at byte 64, fcs_en=1 -> 12 IGAP, 1 IRDY, 8 IPRM, 64 IPAY (64 sdat_rd), 4 IFCS; frm_done at the last FCS byte; frm_err=0.
- 10-byte payload -> 10 IPAY + 50 IPAD bytes, frm_len reaches 60, then 4 IFCS. With fcs_en=0 instead: IGAP directly after pad byte 60, frm_done on that byte.
- sdat_err at payload byte 5 of a 100-byte frame -> IFCE for 4 bytes; frm_err=1 with frm_done. No eop within 1514 bytes -> abort to IFCE after byte 1514, sdat_rd low afterwards, frm_err=1.
- pau_ld with pau_qnt=2 while idle, sreq=1 -> IDIS for 128 txen cycles (pau_busy high), then IRDY->IPRM. pau_req during IDIS -> pause frame sent: 8 IPRM, 60 IPAU, 4 IFCS.
- istable dropped mid-IPAY -> IGAP next cycle, frm_len=0, pause counter unchanged. up_en dropped -> pause counter 0.
- txen toggling 1/0 -> state and counters frozen on txen=0 cycles; field lengths measured in txen cycles are identical to the first test.
